// File: rtl/led_pkg.sv
// Shared definitions for the breathing-LED demo.
// Contents:
//   - led_state_e : ramp FSM states (encoding is visible on the phase port)
//   - default parameter values for the 16 MHz TinyFPGA B2 board
//   - cnt_width() : counter width helper; returns at least one bit
package led_pkg;

    localparam int CLK_HZ         = 16_000_000;
    localparam int PWM_BITS_DEF   = 8;
    localparam int STEP_DIV_DEF   = 16000;
    localparam int HOLD_STEPS_DEF = 64;

    typedef enum logic [1:0] {
        RAMP_UP   = 2'd0,
        HOLD_HI   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD_LO   = 2'd3
    } led_state_e;

    // Width needed to count 0..n-1. A 1-bit counter is kept for n <= 1 so
    // that no zero-width vector ever appears.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated tick generator, reusable by other board demos.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (counter back to 0)
//   en   - count enable; low freezes the counter in place
//   tick - high for the one cycle in which the counter sits at DIV-1 with en high
// With DIV=1 the tick is simply en.
module tick_prescaler
    import led_pkg::*;
#(
    parameter int DIV = STEP_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int             CW   = cnt_width(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CW-1:0] presc_r;
    logic          at_last_s;

    assign at_last_s = (presc_r == LAST);

    // Prescale counter: advances only while enabled, wraps at DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= ZERO;
        end else if (en) begin
            presc_r <= at_last_s ? ZERO : (presc_r + ONE);
        end else begin
            presc_r <= presc_r;
        end
    end

    // The tick is decoded from the counter so the consumer acts on the same
    // edge that wraps the counter.
    assign tick = en & at_last_s;

endmodule

// File: rtl/led_breathe_pwm.sv
// Breathing LED driver: a duty ramp (up, hold, down, hold) paced by a
// prescaler feeds a free-running PWM comparator that drives the LED.
// Ports:
//   pin3_clk_16mhz - board clock, all logic on the rising edge
//   rst            - synchronous active-high reset
//   en             - run enable; low freezes the ramp and blanks the LED
//   pin13          - registered PWM LED drive
//   duty           - current ramp duty (visibility only)
//   phase          - current ramp state encoding
module led_breathe_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int STEP_DIV   = STEP_DIV_DEF,
    parameter int HOLD_STEPS = HOLD_STEPS_DEF
) (
    input  logic                pin3_clk_16mhz,
    input  logic                rst,
    input  logic                en,
    output logic                pin13,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          phase
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_MIN = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
    localparam int                  HW       = cnt_width(HOLD_STEPS);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [HW-1:0]       HOLD_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0]       HOLD_ONE  = HW'(1);

    logic                step_tick_s;
    led_state_e          state_r,    state_nxt_s;
    logic [PWM_BITS-1:0] duty_r,     duty_nxt_s;
    logic [HW-1:0]       hold_cnt_r, hold_cnt_nxt_s;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] duty_lat_r;
    logic                pin13_r;

    tick_prescaler #(
        .DIV (STEP_DIV)
    ) u_presc (
        .clk  (pin3_clk_16mhz),
        .rst  (rst),
        .en   (en),
        .tick (step_tick_s)
    );

    // Ramp FSM state, duty and hold counter registers.
    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            state_r    <= RAMP_UP;
            duty_r     <= DUTY_MIN;
            hold_cnt_r <= HOLD_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            duty_r     <= duty_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end

    // Ramp FSM next state. The end of each ramp is detected before the
    // duty would step, so the duty saturates instead of wrapping. Without a
    // step tick everything holds, which is also how en=0 freezes the ramp.
    always_comb begin
        state_nxt_s    = state_r;
        duty_nxt_s     = duty_r;
        hold_cnt_nxt_s = hold_cnt_r;
        if (step_tick_s) begin
            case (state_r)
                RAMP_UP: begin
                    if (duty_r == DUTY_MAX) begin
                        state_nxt_s    = HOLD_HI;
                        hold_cnt_nxt_s = HOLD_ZERO;
                    end else begin
                        duty_nxt_s = duty_r + DUTY_ONE;
                    end
                end
                HOLD_HI: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_nxt_s = RAMP_DOWN;
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
                    end
                end
                RAMP_DOWN: begin
                    if (duty_r == DUTY_MIN) begin
                        state_nxt_s    = HOLD_LO;
                        hold_cnt_nxt_s = HOLD_ZERO;
                    end else begin
                        duty_nxt_s = duty_r - DUTY_ONE;
                    end
                end
                HOLD_LO: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_nxt_s = RAMP_UP;
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
                    end
                end
                default: begin
                    state_nxt_s    = RAMP_UP;
                    duty_nxt_s     = DUTY_MIN;
                    hold_cnt_nxt_s = HOLD_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // PWM counter, period-boundary duty latch and registered LED compare.
    // The duty is sampled only on the last count of a period so a ramp step
    // never cuts a PWM period short or stretches it.
    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            pwm_cnt_r  <= DUTY_MIN;
            duty_lat_r <= DUTY_MIN;
            pin13_r    <= 1'b0;
        end else begin
            pwm_cnt_r  <= pwm_cnt_r + DUTY_ONE;
            duty_lat_r <= (pwm_cnt_r == DUTY_MAX) ? duty_r : duty_lat_r;
            pin13_r    <= en & (pwm_cnt_r < duty_lat_r);
        end
    end

    assign pin13 = pin13_r;
    assign duty  = duty_r;
    assign phase = state_r;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Self-checking bench for led_breathe_pwm (PWM_BITS=4, STEP_DIV=2,
// HOLD_STEPS=3, plus a STEP_DIV=1 copy sharing the same inputs).
// The reference model derives the ramp position from the number of enabled
// clocks since reset and the PWM output from the duty history.
module tb_led_breathe_pwm;

    localparam int PB   = 4;
    localparam int SD   = 2;
    localparam int HS   = 3;
    localparam int MAXD = (1 << PB) - 1;
    localparam int PER  = 1 << PB;
    localparam int LT   = 2 * MAXD + 2 + 2 * HS;   // ticks per breathing cycle

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          pin13,   pin13_b;
    logic [PB-1:0] duty,    duty_b;
    logic [1:0]    phase,   phase_b;

    always #5 clk = ~clk;

    led_breathe_pwm #(.PWM_BITS(PB), .STEP_DIV(SD), .HOLD_STEPS(HS)) dut (
        .pin3_clk_16mhz (clk),
        .rst            (rst),
        .en             (en),
        .pin13          (pin13),
        .duty           (duty),
        .phase          (phase)
    );

    led_breathe_pwm #(.PWM_BITS(PB), .STEP_DIV(1), .HOLD_STEPS(HS)) dut_fast (
        .pin3_clk_16mhz (clk),
        .rst            (rst),
        .en             (en),
        .pin13          (pin13_b),
        .duty           (duty_b),
        .phase          (phase_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int            n_edge;
    int            en_cyc;
    int            duty_hist[$];   // duty after each edge since reset
    logic [PB-1:0] exp_duty, exp_duty_b;
    logic [1:0]    exp_phase, exp_phase_b;
    logic          exp_pin;

    // Position in the breathing cycle after k step ticks.
    function automatic void ref_point(input int k, output int ph, output int du);
        int t;
        t = k % LT;
        if (t <= MAXD) begin
            ph = 0; du = t;
        end else if (t <= MAXD + HS) begin
            ph = 1; du = MAXD;
        end else if (t <= 2 * MAXD + 1 + HS) begin
            ph = 2; du = MAXD - (t - MAXD - 1 - HS);
        end else begin
            ph = 3; du = 0;
        end
    endfunction

    // Duty in force for the PWM compare after m edges since reset.
    function automatic int lat_at(input int m);
        return (m >= PER) ? duty_hist[PER * (m / PER) - 1] : 0;
    endfunction

    task automatic step();
        int ph, du;
        @(posedge clk);
        if (rst) begin
            n_edge = 0;
            en_cyc = 0;
            duty_hist = {0};
            exp_pin = 1'b0;
        end else begin
            exp_pin = en && ((n_edge % PER) < lat_at(n_edge));
            n_edge++;
            if (en) en_cyc++;
            ref_point(en_cyc / SD, ph, du);
            duty_hist.push_back(du);
        end
        ref_point(en_cyc / SD, ph, du);
        exp_duty  = PB'(du);
        exp_phase = 2'(ph);
        ref_point(en_cyc, ph, du);
        exp_duty_b  = PB'(du);
        exp_phase_b = 2'(ph);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (pin13 !== 1'b0 || duty !== 4'd0 || phase !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_hold: pin13=%b duty=%0d phase=%0d, want 0/0/0", pin13, duty, phase);
            end
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (pin13 !== 1'b0 || duty !== 4'd0 || phase !== 2'd0 || duty_b !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_release: pin13=%b duty=%0d phase=%0d duty_b=%0d, want 0/0/0/1",
                     pin13, duty, phase, duty_b);
        end
    endtask

    task automatic test_ramp_up();
        while (en_cyc < 30) begin
            step();
            n_tests++;
            if (duty !== exp_duty || phase !== exp_phase || pin13 !== exp_pin) begin
                n_fail++;
                $display("FAIL ramp_up: cyc=%0d duty=%0d phase=%0d pin13=%b, want %0d/%0d/%b",
                         en_cyc, duty, phase, pin13, exp_duty, exp_phase, exp_pin);
            end
        end
        n_tests++;
        if (duty !== 4'd15 || phase !== 2'd0) begin
            n_fail++;
            $display("FAIL ramp_top: duty=%0d phase=%0d, want 15/0", duty, phase);
        end
        step();
        step();
        n_tests++;
        if (duty !== 4'd15 || phase !== 2'd1) begin
            n_fail++;
            $display("FAIL enter_hold_hi: duty=%0d phase=%0d, want 15/1", duty, phase);
        end
    endtask

    task automatic test_hold_ramp_down();
        while (en_cyc < 76) begin
            step();
            n_tests++;
            if (duty !== exp_duty || phase !== exp_phase || pin13 !== exp_pin) begin
                n_fail++;
                $display("FAIL hold_down: cyc=%0d duty=%0d phase=%0d pin13=%b, want %0d/%0d/%b",
                         en_cyc, duty, phase, pin13, exp_duty, exp_phase, exp_pin);
            end
            if (en_cyc == 38 || en_cyc == 70) begin
                n_tests++;
                if ((en_cyc == 38 && (phase !== 2'd2 || duty !== 4'd15)) ||
                    (en_cyc == 70 && (phase !== 2'd3 || duty !== 4'd0))) begin
                    n_fail++;
                    $display("FAIL phase_edge: cyc=%0d duty=%0d phase=%0d", en_cyc, duty, phase);
                end
            end
        end
        n_tests++;
        if (duty !== 4'd0 || phase !== 2'd0) begin
            n_fail++;
            $display("FAIL full_cycle_76: duty=%0d phase=%0d, want 0/0", duty, phase);
        end
    endtask

    task automatic test_pwm_latch();
        int highs0, highs1, first_hi;
        rst = 1'b1; en = 1'b1;
        step();
        rst = 1'b0;
        highs0 = 0; highs1 = 0; first_hi = -1;
        for (int i = 1; i <= 32; i++) begin
            step();
            n_tests++;
            if (pin13 !== exp_pin) begin
                n_fail++;
                $display("FAIL pwm_cycle: edge=%0d pin13=%b want %b", n_edge, pin13, exp_pin);
            end
            if (i <= 16 && pin13 === 1'b1) highs0++;
            if (i > 16 && pin13 === 1'b1) begin
                highs1++;
                if (first_hi < 0) first_hi = i;
            end
        end
        // duty ramps mid-period but the first period's latch is still 0
        n_tests++;
        if (highs0 !== 0) begin
            n_fail++;
            $display("FAIL latch_hold: highs=%0d want 0", highs0);
        end
        // latched at edge 16 from duty after 15 edges = 7; lag puts first high at edge 17
        n_tests++;
        if (highs1 !== 7 || first_hi !== 17) begin
            n_fail++;
            $display("FAIL pwm_width: highs=%0d first=%0d want 7/17", highs1, first_hi);
        end
    endtask

    task automatic test_enable_freeze();
        rst = 1'b1; en = 1'b1;
        step();
        rst = 1'b0;
        while (en_cyc < 14) step();
        n_tests++;
        if (duty !== 4'd7 || phase !== 2'd0) begin
            n_fail++;
            $display("FAIL pre_freeze: duty=%0d phase=%0d want 7/0", duty, phase);
        end
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (pin13 !== 1'b0 || duty !== 4'd7 || phase !== 2'd0) begin
                n_fail++;
                $display("FAIL freeze: pin13=%b duty=%0d phase=%0d want 0/7/0", pin13, duty, phase);
            end
        end
        en = 1'b1;
        step();
        n_tests++;
        if (duty !== 4'd7) begin
            n_fail++;
            $display("FAIL resume_1: duty=%0d want 7", duty);
        end
        step();
        n_tests++;
        if (duty !== 4'd8 || phase !== 2'd0) begin
            n_fail++;
            $display("FAIL resume_2: duty=%0d phase=%0d want 8/0", duty, phase);
        end
    endtask

    task automatic test_reset_mid_hold();
        int budget;
        budget = 0;
        while (phase !== 2'd1 && budget < 200) begin
            step();
            budget++;
        end
        n_tests++;
        if (phase !== 2'd1) begin
            n_fail++;
            $display("FAIL reach_hold_timeout: phase=%0d want 1", phase);
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (duty !== 4'd0 || phase !== 2'd0 || pin13 !== 1'b0 || duty_b !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: duty=%0d phase=%0d pin13=%b duty_b=%0d want 0/0/0/0",
                     duty, phase, pin13, duty_b);
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_tests++;
            if (duty !== PB'(i / 2) || duty_b !== PB'(i) || phase !== 2'd0) begin
                n_fail++;
                $display("FAIL restart: i=%0d duty=%0d duty_b=%0d phase=%0d want %0d/%0d/0",
                         i, duty, duty_b, phase, i / 2, i);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            en  = ($urandom_range(0, 5) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            n_tests++;
            if (duty !== exp_duty || phase !== exp_phase || pin13 !== exp_pin ||
                duty_b !== exp_duty_b || phase_b !== exp_phase_b) begin
                n_fail++;
                $display("FAIL random: i=%0d duty=%0d phase=%0d pin13=%b duty_b=%0d phase_b=%0d want %0d/%0d/%b/%0d/%0d",
                         i, duty, phase, pin13, duty_b, phase_b,
                         exp_duty, exp_phase, exp_pin, exp_duty_b, exp_phase_b);
            end
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        test_reset();
        test_ramp_up();
        test_hold_ramp_down();
        test_pwm_latch();
        test_enable_freeze();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
